// File: rtl/hci_queue_bank.sv
// Bank of NUM_Q independent first-word-fall-through FIFOs with threshold and sticky error flags.
// Optional high-water-mark tracking is enabled by defining HCI_QUEUE_PEAK_EN.
module hci_queue_bank #(
  parameter  int NUM_Q  = 4,
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 64,
  parameter  int THLD_W = 8,
  localparam int DW     = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_Q-1:0]        clr_i,
  input  logic [NUM_Q*THLD_W-1:0] thld_i,
  input  logic [NUM_Q-1:0]        thld_mode_i,
  input  logic [NUM_Q-1:0]        wvalid_i,
  output logic [NUM_Q-1:0]        wready_o,
  input  logic [NUM_Q*WIDTH-1:0]  wdata_i,
  output logic [NUM_Q-1:0]        rvalid_o,
  input  logic [NUM_Q-1:0]        rready_i,
  output logic [NUM_Q*WIDTH-1:0]  rdata_o,
  output logic [NUM_Q*DW-1:0]     depth_o,
  output logic [NUM_Q-1:0]        full_o,
  output logic [NUM_Q-1:0]        empty_o,
  output logic [NUM_Q-1:0]        apch_thld_o,
  output logic [NUM_Q-1:0]        ovf_o,
  output logic [NUM_Q-1:0]        udf_o,
  input  logic [NUM_Q-1:0]        err_clr_i,
  output logic [NUM_Q*DW-1:0]     peak_depth_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ((THLD_W > DW) ? THLD_W : DW) + 1;
  localparam logic [DW-1:0] DEPTH_DW = DW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             apch_q, apch_d, ovf_q, ovf_d, udf_q, udf_d;
    logic             full_s, empty_s, wr_s, rd_s;
    logic [CW-1:0]    thld_s, level_s;

    always_comb begin
      full_s  = (depth_q == DEPTH_DW);
      empty_s = (depth_q == DW'(0));
      // A flush swallows any same-cycle traffic and its error side effects.
      wr_s    = wvalid_i[q] & ~full_s  & ~clr_i[q];
      rd_s    = rready_i[q] & ~empty_s & ~clr_i[q];

      if (clr_i[q]) begin
        wptr_d  = '0;
        rptr_d  = '0;
        depth_d = '0;
      end else begin
        if (wr_s) begin
          wptr_d = (wptr_q == LAST_PTR) ? PW'(0) : wptr_q + PW'(1);
        end else begin
          wptr_d = wptr_q;
        end
        if (rd_s) begin
          rptr_d = (rptr_q == LAST_PTR) ? PW'(0) : rptr_q + PW'(1);
        end else begin
          rptr_d = rptr_q;
        end
        if (wr_s && !rd_s) begin
          depth_d = depth_q + DW'(1);
        end else if (rd_s && !wr_s) begin
          depth_d = depth_q - DW'(1);
        end else begin
          depth_d = depth_q;
        end
      end

      if (wvalid_i[q] && full_s && !clr_i[q]) begin
        ovf_d = 1'b1;
      end else if (err_clr_i[q]) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
      if (rready_i[q] && empty_s && !clr_i[q]) begin
        udf_d = 1'b1;
      end else if (err_clr_i[q]) begin
        udf_d = 1'b0;
      end else begin
        udf_d = udf_q;
      end

      // Compare against the next depth so the flag lines up with depth_o.
      if (thld_i[q*THLD_W +: THLD_W] == THLD_W'(0)) begin
        thld_s = CW'(1);
      end else begin
        thld_s = CW'(thld_i[q*THLD_W +: THLD_W]);
      end
      if (thld_mode_i[q]) begin
        level_s = CW'(DEPTH) - CW'(depth_d);
      end else begin
        level_s = CW'(depth_d);
      end
      apch_d = (level_s >= thld_s);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        depth_q <= '0;
        apch_q  <= 1'b0;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        depth_q <= depth_d;
        apch_q  <= apch_d;
        ovf_q   <= ovf_d;
        udf_q   <= udf_d;
      end
    end

    always_ff @(posedge clk_i) begin
      if (wr_s) begin
        mem[wptr_q] <= wdata_i[q*WIDTH +: WIDTH];
      end
    end

    assign wready_o[q]               = ~full_s;
    assign rvalid_o[q]               = ~empty_s;
    assign rdata_o[q*WIDTH +: WIDTH] = empty_s ? WIDTH'(0) : mem[rptr_q];
    assign depth_o[q*DW +: DW]       = depth_q;
    assign full_o[q]                 = full_s;
    assign empty_o[q]                = empty_s;
    assign apch_thld_o[q]            = apch_q;
    assign ovf_o[q]                  = ovf_q;
    assign udf_o[q]                  = udf_q;

`ifdef HCI_QUEUE_PEAK_EN
    logic [DW-1:0] peak_q, peak_d;

    always_comb begin
      if (clr_i[q]) begin
        peak_d = '0;
      end else if (depth_d > peak_q) begin
        peak_d = depth_d;
      end else begin
        peak_d = peak_q;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        peak_q <= '0;
      end else begin
        peak_q <= peak_d;
      end
    end

    assign peak_depth_o[q*DW +: DW] = peak_q;
`else
    assign peak_depth_o[q*DW +: DW] = DW'(0);
`endif
  end

endmodule

// File: tb/tb_hci_queue_bank.sv
// Directed self-checking bench for hci_queue_bank: a 4x64 bank plus a 1x5 bank for wrap checks.
module tb_hci_queue_bank;
  localparam int NQ = 4;
  localparam int W  = 32;
  localparam int D  = 64;
  localparam int TW = 8;
  localparam int DW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NQ-1:0]    clr, thld_mode, wvalid, wready, rvalid, rready, full, empty, apch, ovf, udf, err_clr;
  logic [NQ*TW-1:0] thld;
  logic [NQ*W-1:0]  wdata, rdata;
  logic [NQ*DW-1:0] depth, peak;

  logic        clr5, mode5, wv5, wr5, rv5, rr5, full5, empty5, apch5, ovf5, udf5, ec5;
  logic [7:0]  thld5;
  logic [31:0] wd5, rd5;
  logic [2:0]  dep5, peak5;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_peak;

  hci_queue_bank #(.NUM_Q(NQ), .WIDTH(W), .DEPTH(D), .THLD_W(TW)) u_dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .thld_i(thld), .thld_mode_i(thld_mode),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .rvalid_o(rvalid),
    .rready_i(rready), .rdata_o(rdata), .depth_o(depth), .full_o(full), .empty_o(empty),
    .apch_thld_o(apch), .ovf_o(ovf), .udf_o(udf), .err_clr_i(err_clr), .peak_depth_o(peak)
  );

  hci_queue_bank #(.NUM_Q(1), .WIDTH(32), .DEPTH(5), .THLD_W(8)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr5), .thld_i(thld5), .thld_mode_i(mode5),
    .wvalid_i(wv5), .wready_o(wr5), .wdata_i(wd5), .rvalid_o(rv5),
    .rready_i(rr5), .rdata_o(rd5), .depth_o(dep5), .full_o(full5), .empty_o(empty5),
    .apch_thld_o(apch5), .ovf_o(ovf5), .udf_o(udf5), .err_clr_i(ec5), .peak_depth_o(peak5)
  );

  function automatic logic [6:0] dep(input int q);
    return depth[q*DW +: DW];
  endfunction

  function automatic logic [31:0] head(input int q);
    return rdata[q*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (depth !== '0) begin errors++; $display("FAIL rst_depth got=%h exp=0", depth); end
    checks++; if (empty !== 4'hF) begin errors++; $display("FAIL rst_empty got=%b exp=1111", empty); end
    checks++; if (full !== 4'h0 || wready !== 4'hF) begin errors++; $display("FAIL rst_full_wready got=%b/%b exp=0000/1111", full, wready); end
    checks++; if (rvalid !== 4'h0 || rdata !== '0) begin errors++; $display("FAIL rst_rvalid_rdata got=%b/%h exp=0/0", rvalid, rdata); end
    checks++; if (apch !== 4'h0 || ovf !== 4'h0 || udf !== 4'h0) begin errors++; $display("FAIL rst_flags got=%b/%b/%b exp=0/0/0", apch, ovf, udf); end
    checks++; if (peak !== '0) begin errors++; $display("FAIL rst_peak got=%h exp=0", peak); end
    rst = 1'b0;
    tick();
    checks++; if (apch !== 4'b0001) begin errors++; $display("FAIL rst_apch_first_edge got=%b exp=0001", apch); end
    checks++; if (dep(0) !== 7'd0 || empty[0] !== 1'b1) begin errors++; $display("FAIL idle_q0 got=%0d/%b exp=0/1", dep(0), empty[0]); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 64; i++) begin
      wvalid[1] = 1'b1;
      wdata[63:32] = 32'(i);
      tick();
      checks++; if (dep(1) !== 7'(i) || apch[1] !== (i >= 64)) begin errors++; $display("FAIL fill_depth_apch i=%0d got=%0d/%b exp=%0d/%b", i, dep(1), apch[1], i, (i >= 64)); end
    end
    checks++; if (full[1] !== 1'b1 || wready[1] !== 1'b0) begin errors++; $display("FAIL full_flag got=%b/%b exp=1/0", full[1], wready[1]); end
    wdata[63:32] = 32'hDEAD;
    tick();
    wvalid[1] = 1'b0;
    checks++; if (ovf[1] !== 1'b1 || dep(1) !== 7'd64) begin errors++; $display("FAIL overflow got=%b/%0d exp=1/64", ovf[1], dep(1)); end
    for (int i = 1; i <= 64; i++) begin
      checks++; if (rvalid[1] !== 1'b1 || head(1) !== 32'(i)) begin errors++; $display("FAIL drain_order i=%0d got=%b/%h exp=1/%h", i, rvalid[1], head(1), i); end
      rready[1] = 1'b1;
      tick();
    end
    rready[1] = 1'b0;
    checks++; if (empty[1] !== 1'b1 || head(1) !== 32'h0) begin errors++; $display("FAIL drained_empty got=%b/%h exp=1/0", empty[1], head(1)); end
    checks++; if (ovf[1] !== 1'b1 || udf[1] !== 1'b0) begin errors++; $display("FAIL sticky_ovf got=%b/%b exp=1/0", ovf[1], udf[1]); end
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL err_clr_ovf got=%b exp=0", ovf[1]); end
  endtask

  task automatic test_simul();
    wvalid[2] = 1'b1;
    wdata[95:64] = 32'hA0;
    checks++; if (rvalid[2] !== 1'b0) begin errors++; $display("FAIL no_bypass got=%b exp=0", rvalid[2]); end
    tick();
    checks++; if (rvalid[2] !== 1'b1 || head(2) !== 32'hA0 || apch[2] !== 1'b1) begin errors++; $display("FAIL fwft_latency got=%b/%h/%b exp=1/a0/1", rvalid[2], head(2), apch[2]); end
    wdata[95:64] = 32'hA1;
    tick();
    wdata[95:64] = 32'hA2;
    tick();
    wdata[95:64] = 32'hA3;
    rready[2] = 1'b1;
    tick();
    wvalid[2] = 1'b0;
    checks++; if (dep(2) !== 7'd3 || head(2) !== 32'hA1) begin errors++; $display("FAIL simul_rw got=%0d/%h exp=3/a1", dep(2), head(2)); end
    for (int k = 1; k <= 3; k++) begin
      checks++; if (head(2) !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL simul_drain k=%0d got=%h exp=%h", k, head(2), 32'hA0 + 32'(k)); end
      tick();
    end
    rready[2] = 1'b0;
    checks++; if (empty[2] !== 1'b1 || udf[2] !== 1'b0) begin errors++; $display("FAIL simul_end got=%b/%b exp=1/0", empty[2], udf[2]); end
  endtask

  task automatic test_clr();
    rready[3] = 1'b1;
    tick();
    rready[3] = 1'b0;
    checks++; if (udf[3] !== 1'b1 || dep(3) !== 7'd0) begin errors++; $display("FAIL underflow got=%b/%0d exp=1/0", udf[3], dep(3)); end
    wvalid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wdata[127:96] = 32'h300 + 32'(i);
      tick();
    end
    checks++; if (dep(3) !== 7'd10 || apch[3] !== 1'b0) begin errors++; $display("FAIL pre_clr got=%0d/%b exp=10/0", dep(3), apch[3]); end
    clr[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    wvalid[3] = 1'b0;
    checks++; if (dep(3) !== 7'd0 || empty[3] !== 1'b1) begin errors++; $display("FAIL clr_depth got=%0d/%b exp=0/1", dep(3), empty[3]); end
    checks++; if (udf[3] !== 1'b1 || ovf[3] !== 1'b0) begin errors++; $display("FAIL clr_keeps_errs got=%b/%b exp=1/0", udf[3], ovf[3]); end
    err_clr[3] = 1'b1;
    tick();
    err_clr[3] = 1'b0;
    checks++; if (udf[3] !== 1'b0) begin errors++; $display("FAIL err_clr_udf got=%b exp=0", udf[3]); end
    clr[3] = 1'b1;
    rready[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    rready[3] = 1'b0;
    checks++; if (udf[3] !== 1'b0 || dep(3) !== 7'd0) begin errors++; $display("FAIL clr_masks_udf got=%b/%0d exp=0/0", udf[3], dep(3)); end
  endtask

  task automatic test_err_set_wins();
    rready[0] = 1'b1;
    err_clr[0] = 1'b1;
    tick();
    rready[0] = 1'b0;
    checks++; if (udf[0] !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", udf[0]); end
    tick();
    err_clr[0] = 1'b0;
    checks++; if (udf[0] !== 1'b0) begin errors++; $display("FAIL clear_after got=%b exp=0", udf[0]); end
  endtask

  task automatic test_peak();
`ifdef HCI_QUEUE_PEAK_EN
    exp_peak = 7'd40;
`else
    exp_peak = 7'd0;
`endif
    wvalid[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata[31:0] = 32'h500 + 32'(i);
      tick();
    end
    wvalid[0] = 1'b0;
    checks++; if (dep(0) !== 7'd40 || apch[0] !== 1'b1 || peak[6:0] !== exp_peak) begin errors++; $display("FAIL fill40 got=%0d/%b/%0d exp=40/1/%0d", dep(0), apch[0], peak[6:0], exp_peak); end
    rready[0] = 1'b1;
    repeat (38) tick();
    rready[0] = 1'b0;
    checks++; if (dep(0) !== 7'd2 || head(0) !== 32'h526 || peak[6:0] !== exp_peak) begin errors++; $display("FAIL drain2 got=%0d/%h/%0d exp=2/526/%0d", dep(0), head(0), peak[6:0], exp_peak); end
    thld_mode[0] = 1'b0;
    tick();
    checks++; if (apch[0] !== 1'b0) begin errors++; $display("FAIL mode_fill got=%b exp=0", apch[0]); end
    thld_mode[0] = 1'b1;
    tick();
    checks++; if (apch[0] !== 1'b1) begin errors++; $display("FAIL mode_space got=%b exp=1", apch[0]); end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    checks++; if (dep(0) !== 7'd0 || peak[6:0] !== 7'd0) begin errors++; $display("FAIL peak_clr got=%0d/%0d exp=0/0", dep(0), peak[6:0]); end
  endtask

  task automatic test_wrap();
    int nw;
    int nr;
    nw = 1;
    nr = 1;
    wv5 = 1'b1;
    repeat (3) begin
      wd5 = 32'(nw); nw++;
      tick();
    end
    for (int c = 0; c < 9; c++) begin
      wd5 = 32'(nw); nw++;
      checks++; if (rv5 !== 1'b1 || rd5 !== 32'(nr)) begin errors++; $display("FAIL wrap_order c=%0d got=%b/%0d exp=1/%0d", c, rv5, rd5, nr); end
      rr5 = 1'b1;
      tick();
      nr++;
      checks++; if (dep5 !== 3'd3) begin errors++; $display("FAIL wrap_depth c=%0d got=%0d exp=3", c, dep5); end
    end
    wv5 = 1'b0;
    repeat (3) begin
      checks++; if (rd5 !== 32'(nr)) begin errors++; $display("FAIL wrap_drain got=%0d exp=%0d", rd5, nr); end
      tick();
      nr++;
    end
    rr5 = 1'b0;
    checks++; if (empty5 !== 1'b1 || nr !== 13) begin errors++; $display("FAIL wrap_empty got=%b/%0d exp=1/13", empty5, nr); end
    wv5 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wd5 = 32'(nw); nw++;
      tick();
      checks++; if (dep5 > 3'd5) begin errors++; $display("FAIL depth_bound i=%0d got=%0d exp<=5", i, dep5); end
    end
    wv5 = 1'b0;
    checks++; if (full5 !== 1'b1 || wr5 !== 1'b0 || ovf5 !== 1'b1 || apch5 !== 1'b1) begin errors++; $display("FAIL small_full got=%b/%b/%b/%b exp=1/0/1/1", full5, wr5, ovf5, apch5); end
    rr5 = 1'b1;
    repeat (5) begin
      checks++; if (rd5 !== 32'(nr)) begin errors++; $display("FAIL small_order got=%0d exp=%0d", rd5, nr); end
      tick();
      nr++;
    end
    rr5 = 1'b0;
    checks++; if (empty5 !== 1'b1 || dep5 !== 3'd0) begin errors++; $display("FAIL small_empty got=%b/%0d exp=1/0", empty5, dep5); end
  endtask

  task automatic test_async_reset();
    wvalid[1] = 1'b1;
    rready[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata[63:32] = 32'h700 + 32'(i);
      tick();
    end
    checks++; if (dep(1) !== 7'd5 || udf[2] !== 1'b1) begin errors++; $display("FAIL burst_setup got=%0d/%b exp=5/1", dep(1), udf[2]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (depth !== '0 || empty !== 4'hF || rvalid !== 4'h0 || rdata !== '0) begin errors++; $display("FAIL async_rst_data got=%h/%b/%b exp=0/1111/0000", depth, empty, rvalid); end
    checks++; if (apch !== 4'h0 || ovf !== 4'h0 || udf !== 4'h0 || wready !== 4'hF || peak !== '0) begin errors++; $display("FAIL async_rst_flags got=%b/%b/%b/%b exp=0/0/0/1111", apch, ovf, udf, wready); end
    checks++; if (ovf5 !== 1'b0 || dep5 !== 3'd0) begin errors++; $display("FAIL async_rst_small got=%b/%0d exp=0/0", ovf5, dep5); end
    wvalid = '0;
    rready = '0;
    rst = 1'b0;
    tick();
    checks++; if (dep(1) !== 7'd0 || rvalid !== 4'h0) begin errors++; $display("FAIL post_rst got=%0d/%b exp=0/0000", dep(1), rvalid); end
  endtask

  initial begin
    rst = 1'b1;
    clr = '0; wvalid = '0; rready = '0; err_clr = '0; wdata = '0;
    thld = {8'd200, 8'd0, 8'd64, 8'd16};
    thld_mode = 4'b1001;
    clr5 = 1'b0; mode5 = 1'b0; wv5 = 1'b0; rr5 = 1'b0; ec5 = 1'b0; wd5 = '0;
    thld5 = 8'd2;
    exp_peak = '0;
    test_reset();
    test_fill_drain();
    test_simul();
    test_clr();
    test_err_set_wins();
    test_peak();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
